emb_layer: RTL and testbench

EMB_LAYER -- requirements
Module: emb_layer

---
 rtl/emb_layer_pkg.sv | 28 ++
 rtl/emb_rom.sv | 17 +
 rtl/emb_layer.sv | 95 +++++++++
 tb/tb_emb_layer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/emb_layer_pkg.sv
// Shared embedding-layer constants (trained-model dimensions) and the table row generator.
package emb_layer_pkg;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int CHAR_LEN = 8;
  localparam int EMB_DIM  = 24;
  localparam int N_LEN    = 16;

  localparam int ROW_W = EMB_DIM * N_LEN;
  localparam int D_W   = N * CHAR_LEN;
  localparam int Q_W   = N * ROW_W;
  localparam int CNT_W = $clog2(N);

  typedef logic [CHAR_LEN-1:0] char_idx_t;
  typedef logic [ROW_W-1:0]    row_t;

  // Table contents: row r element e = (r*EMB_DIM + e) mod 2^N_LEN.
  function automatic row_t table_row(input char_idx_t idx);
    row_t row;
    row = '0;
    for (int e = 0; e < EMB_DIM; e++) begin
      row[e*N_LEN +: N_LEN] = N_LEN'(int'(idx) * EMB_DIM + e);
    end
    return row;
  endfunction

endpackage

// File: rtl/emb_rom.sv
// Embedding table with a registered read port (one-cycle synchronous lookup).
// Contents come from table_row(), which holds the emb_rom.hex image as a constant table.
module emb_rom
  import emb_layer_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  char_idx_t addr,
  output row_t      row
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) row <= '0;
    else        row <= table_row(addr);
  end

endmodule

// File: rtl/emb_layer.sv
// Embedding lookup: latches N character indices and maps each to its table row, one per cycle.
// Optional EMB_OOR_ZERO_EN zeroes rows for indices >= CHAR_NUM.
//
// state  | meaning
// IDLE   | waiting for run (ignored during the valid cycle)
// READ   | issuing one table address per cycle for positions 0..N-1
// DONE   | last row lands in q; valid pulses next cycle
module emb_layer
  import emb_layer_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [D_W-1:0] d,
  output logic           busy,
  output logic           valid,
  output logic [Q_W-1:0] q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wr_pos;
  logic             wr_en;
  logic [D_W-1:0]   d_lat;
  char_idx_t        rd_addr;
  row_t             rom_row;
  row_t             wr_row;

  assign rd_addr = d_lat[int'(cnt)*CHAR_LEN +: CHAR_LEN];

  emb_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (rd_addr),
    .row   (rom_row)
  );

`ifdef EMB_OOR_ZERO_EN
  // Range flag travels alongside the ROM read so it lines up with the returned row.
  logic oor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oor_q <= 1'b0;
    else        oor_q <= (rd_addr >= CHAR_LEN'(CHAR_NUM));
  end

  assign wr_row = oor_q ? '0 : rom_row;
`else
  assign wr_row = rom_row;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      d_lat  <= '0;
      wr_en  <= 1'b0;
      wr_pos <= '0;
      q      <= '0;
    end else begin
      valid  <= 1'b0;
      wr_en  <= (state == S_READ);
      wr_pos <= cnt;
      if (wr_en) q[int'(wr_pos)*ROW_W +: ROW_W] <= wr_row;

      case (state)
        S_IDLE: begin
          if (run && !valid) begin
            d_lat <= d;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (cnt == CNT_W'(N-1)) state <= S_DONE;
          else                    cnt   <= cnt + 1'b1;
        end
        S_DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emb_layer.sv
// Directed self-checking bench for emb_layer; define EMB_OOR_ZERO_EN to also check zeroed out-of-range rows.
module tb_emb_layer;
  import emb_layer_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           run = 1'b0;
  logic [D_W-1:0] d = '0;
  logic           busy;
  logic           valid;
  logic [Q_W-1:0] q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  emb_layer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .d     (d),
    .busy  (busy),
    .valid (valid),
    .q     (q)
  );

  localparam logic [Q_W-1:0] ALL = {Q_W{1'b1}};

  function automatic logic [N_LEN-1:0] el(input logic [Q_W-1:0] v, input int s, input int e);
    return v[(s*EMB_DIM + e)*N_LEN +: N_LEN];
  endfunction

  function automatic logic [Q_W-1:0] exp_q(input logic [D_W-1:0] dv);
    logic [Q_W-1:0] x;
    x = '0;
    for (int i = 0; i < N; i++) begin
      for (int e = 0; e < EMB_DIM; e++) begin
        x[(i*EMB_DIM + e)*N_LEN +: N_LEN] = N_LEN'(int'(dv[i*CHAR_LEN +: CHAR_LEN]) * EMB_DIM + e);
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [Q_W-1:0] exp, input logic [Q_W-1:0] mask);
    logic [Q_W-1:0] o;
    logic [Q_W-1:0] x;
    bit found;
    o = q & mask;
    x = exp & mask;
    checks++;
    assert (o === x) else begin
      errors++;
      found = 1'b0;
      for (int s = 0; s < N && !found; s++) begin
        for (int e = 0; e < EMB_DIM && !found; e++) begin
          if (el(o, s, e) !== el(x, s, e)) begin
            found = 1'b1;
            $error("FAIL %s slot=%0d elem=%0d observed=%0h expected=%0h", tag, s, e, el(o, s, e), el(x, s, e));
          end
        end
      end
      if (!found) $error("FAIL %s observed q differs from expected", tag);
    end
  endtask

  task automatic start(input logic [D_W-1:0] dv);
    @(negedge clk);
    run = 1'b1;
    d   = dv;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Counts negedges from the one just after the run edge; valid is due at the 12th.
  task automatic wait_valid(input string tag, input int n0, input bit scramble);
    int n;
    n = n0;
    if (scramble) d = D_W'({$urandom(), $urandom(), $urandom()});
    while (valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (scramble && valid !== 1'b1) d = D_W'({$urandom(), $urandom(), $urandom()});
    end
    chk(tag, n, N + 2);
  endtask

  logic [D_W-1:0] d_seq, d_199, d_rev, d_c, d_r, d_e, d_o;
  logic [Q_W-1:0] oor_mask;
  bit seen;

  initial begin
    for (int i = 0; i < N; i++) begin
      d_seq[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(i);
      d_199[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(199);
      d_rev[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(N - 1 - i);
      d_c[i*CHAR_LEN +: CHAR_LEN]   = CHAR_LEN'(100 + i*3);
      d_r[i*CHAR_LEN +: CHAR_LEN]   = CHAR_LEN'(20 + i*11);
      d_e[i*CHAR_LEN +: CHAR_LEN]   = CHAR_LEN'(3 + i*17);
      d_o[i*CHAR_LEN +: CHAR_LEN]   = CHAR_LEN'((i == 3) ? 250 : 7);
    end
    oor_mask = ALL;
    oor_mask[3*ROW_W +: ROW_W] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk_q("reset_q", '0, ALL);
    rst_n = 1'b1;

    // indices 0..9
    start(d_seq);
    chk("busy_after_run", busy, 1);
    chk("valid_low_after_run", valid, 0);
    wait_valid("latency_seq", 1, 1'b0);
    chk_q("q_seq", exp_q(d_seq), ALL);
    chk("seq_slot9_e23", el(q, 9, 23), 239);
    chk("seq_slot4_e5", el(q, 4, 5), 101);
    @(negedge clk);
    chk("valid_single_pulse", valid, 0);
    chk("busy_clear_after_done", busy, 0);

    // all positions 199; q holds prior result until first write
    start(d_199);
    chk_q("q_hold_before_write", exp_q(d_seq), ALL);
    wait_valid("latency_199", 1, 1'b0);
    chk_q("q_199", exp_q(d_199), ALL);
    chk("s0_e23_4799", el(q, 0, 23), 4799);
    chk("s5_e0_4776", el(q, 5, 0), 4776);

    // run while busy and during valid ignored; run after valid accepted
    start(d_rev);
    @(negedge clk);
    run = 1'b1;
    d   = {D_W{1'b1}};
    @(negedge clk);
    run = 1'b0;
    wait_valid("latency_rev", 3, 1'b0);
    chk_q("q_rev_ignores_busy_run", exp_q(d_rev), ALL);
    run = 1'b1;
    d   = {(D_W/8){8'd60}};
    @(negedge clk);
    chk("run_in_valid_ignored", busy, 0);
    chk_q("q_rev_after_valid", exp_q(d_rev), ALL);
    d = d_c;
    @(negedge clk);
    run = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_valid("latency_b2b", 1, 1'b0);
    chk_q("q_b2b", exp_q(d_c), ALL);

    // reset mid-sequence
    start(d_seq);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk_q("abort_q_zero", '0, ALL);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid !== 1'b0) seen = 1'b1;
    end
    chk("no_valid_after_abort", 32'(seen), 0);
    start(d_r);
    wait_valid("latency_after_reset", 1, 1'b0);
    chk_q("q_after_reset", exp_q(d_r), ALL);

    // d scrambled every cycle while busy
    start(d_e);
    wait_valid("latency_scramble", 1, 1'b1);
    chk_q("q_scramble", exp_q(d_e), ALL);

    // out-of-range index at position 3
    start(d_o);
    wait_valid("latency_oor", 1, 1'b0);
    chk_q("oor_other_slots", exp_q(d_o), oor_mask);
    chk("oor_s0_e0_168", el(q, 0, 0), 168);
    chk("oor_s9_e23_191", el(q, 9, 23), 191);
`ifdef EMB_OOR_ZERO_EN
    chk("oor_slot3_zero", 32'(q[3*ROW_W +: ROW_W] === '0), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
